spi_shift_engine: RTL and testbench

//  Hardware SPI master byte shifter replacing bit-banged SCLK/MOSI at $FE2E-$FE31.

---
 rtl/spi_shift_engine.sv | 143 ++++++++++++++
 tb/tb_spi_shift_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - mode-0 SPI master byte shifter, MSB first, programmable SCLK half-period
module spi_shift_engine #(
    parameter int   DIV_W   = 8,
    parameter logic IDLE_MO = 1'b1
) (
    input  logic             MHZ48,
    input  logic             RES,
    input  logic             WR_STB,
    input  logic             RD_STB,
    input  logic [7:0]       DIN,
    input  logic [DIV_W-1:0] DIV,
    input  logic             AUTO,
    input  logic             MISO,
    output logic [7:0]       DOUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVR,
    output logic             SCLK,
    output logic             MOSI
);

    typedef enum logic [1:0] {
        sIdle = 2'd0,
        sLow  = 2'd1,
        sHigh = 2'd2
    } stateType;

    stateType         state;
    stateType         stateNext;
    logic [DIV_W-1:0] halfCnt;
    logic [DIV_W-1:0] divLatched;
    logic [2:0]       bitCnt;
    logic [6:0]       txRest;
    logic [7:0]       rxShift;

    logic startReq;
    logic halfEnd;
    logic doStart;
    logic doRise;
    logic doFall;
    logic doFinish;

    assign startReq = WR_STB | (AUTO & RD_STB);
    assign halfEnd  = (halfCnt == divLatched);

    always_ff @(posedge MHZ48) begin
        if (RES) begin
            state <= sIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        doStart   = 1'b0;
        doRise    = 1'b0;
        doFall    = 1'b0;
        doFinish  = 1'b0;
        case (state)
            sIdle: begin
                if (startReq) begin
                    stateNext = sLow;
                    doStart   = 1'b1;
                end
            end
            sLow: begin
                if (halfEnd) begin
                    stateNext = sHigh;
                    doRise    = 1'b1;
                end
            end
            sHigh: begin
                if (halfEnd) begin
                    if (bitCnt == 3'd7) begin
                        stateNext = sIdle;
                        doFinish  = 1'b1;
                    end else begin
                        stateNext = sLow;
                        doFall    = 1'b1;
                    end
                end
            end
            default: stateNext = sIdle;
        endcase
    end

    always_ff @(posedge MHZ48) begin
        if (RES) begin
            halfCnt    <= '0;
            divLatched <= '0;
            bitCnt     <= 3'd0;
            txRest     <= 7'd0;
            rxShift    <= 8'h00;
            DOUT       <= 8'h00;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            OVR        <= 1'b0;
            SCLK       <= 1'b0;
            MOSI       <= IDLE_MO;
        end else begin
            DONE    <= 1'b0;
            halfCnt <= (state == sIdle || halfEnd) ? '0 : halfCnt + 1'b1;

            // A write beats an auto-read in the same cycle, so DIN is sent.
            if (doStart) begin
                txRest     <= WR_STB ? DIN[6:0] : 7'h7F;
                MOSI       <= WR_STB ? DIN[7] : 1'b1;
                BUSY       <= 1'b1;
                bitCnt     <= 3'd0;
                divLatched <= DIV;
            end

            if (doRise) begin
                SCLK    <= 1'b1;
                rxShift <= {rxShift[6:0], MISO};
            end

            if (doFall) begin
                SCLK   <= 1'b0;
                MOSI   <= txRest[6];
                txRest <= {txRest[5:0], 1'b0};
                bitCnt <= bitCnt + 3'd1;
            end

            if (doFinish) begin
                SCLK <= 1'b0;
                MOSI <= IDLE_MO;
                DOUT <= rxShift;
                BUSY <= 1'b0;
                DONE <= 1'b1;
            end

            // Setting the overrun flag takes priority over the read that clears it.
            if (startReq && state != sIdle) begin
                OVR <= 1'b1;
            end else if (RD_STB) begin
                OVR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - scoreboard bench for spi_shift_engine
module tb_spi_shift_engine;

    logic       clk = 1'b0;
    logic       res;
    logic       wrStb;
    logic       rdStb;
    logic [7:0] din;
    logic [7:0] div;
    logic       autoRd;
    logic       miso;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       ovr;
    logic       sclk;
    logic       mosi;

    always #5 clk = ~clk;

    spi_shift_engine #(.DIV_W(8), .IDLE_MO(1'b1)) dut (
        .MHZ48 (clk),
        .RES   (res),
        .WR_STB(wrStb),
        .RD_STB(rdStb),
        .DIN   (din),
        .DIV   (div),
        .AUTO  (autoRd),
        .MISO  (miso),
        .DOUT  (dout),
        .BUSY  (busy),
        .DONE  (done),
        .OVR   (ovr),
        .SCLK  (sclk),
        .MOSI  (mosi)
    );

    // Slave model: 0 = loopback, 1 = shift out slaveReg on SCLK falls, 2 = constant 1
    int         misoMode = 0;
    logic [7:0] slaveReg = 8'h00;
    assign miso = (misoMode == 0) ? mosi : (misoMode == 1) ? slaveReg[7] : 1'b1;
    always @(negedge sclk) slaveReg = {slaveReg[6:0], 1'b0};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [7:0] txExp;
        logic [7:0] rxExp;
        int         doneCyc;
        int         firstRise;
        int         period;
    } expType;
    expType sbQ[$];

    task automatic check(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    // Monitor: tracks SCLK rises and MOSI per transfer, compares on DONE
    logic       prevSclk = 1'b0;
    int         riseCnt = 0;
    int         rise1 = 0;
    int         rise2 = 0;
    logic [7:0] mosiSeen = 8'h00;
    always @(negedge clk) begin
        expType e;
        if (res) begin
            riseCnt  = 0;
            mosiSeen = 8'h00;
        end else begin
            if (sclk && !prevSclk) begin
                if (riseCnt == 0) rise1 = cyc;
                if (riseCnt == 1) rise2 = cyc;
                mosiSeen = {mosiSeen[6:0], mosi};
                riseCnt++;
            end
            if (done) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    e = sbQ.pop_front();
                    check("dout", int'(dout), int'(e.rxExp));
                    check("mosi_bits", int'(mosiSeen), int'(e.txExp));
                    check("done_cycle", cyc, e.doneCyc);
                    check("first_rise", rise1, e.firstRise);
                    check("sclk_period", rise2 - rise1, e.period);
                    check("rise_count", riseCnt, 8);
                end
                riseCnt = 0;
            end
        end
        prevSclk = sclk;
    end

    // Issues a start at the next posedge (edge k); returns k
    task automatic startTx(input logic [7:0] d, input int dv, input logic [7:0] rxExp,
                           input bit useWr, input bit pushExp, output int k);
        expType e;
        @(negedge clk);
        div = 8'(dv);
        if (useWr) begin
            wrStb = 1'b1;
            din   = d;
        end else begin
            rdStb = 1'b1;
        end
        k = cyc + 1;
        if (pushExp) begin
            e.txExp     = useWr ? d : 8'hFF;
            e.rxExp     = rxExp;
            e.doneCyc   = k + 16 * (dv + 1);
            e.firstRise = k + (dv + 1);
            e.period    = 2 * (dv + 1);
            sbQ.push_back(e);
        end
        @(negedge clk);
        wrStb = 1'b0;
        rdStb = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout actual=busy expected=idle at cycle %0d", cyc);
        end
    endtask

    initial begin
        int k;
        int kDone;
        expType e;
        res = 1'b1; wrStb = 1'b0; rdStb = 1'b0; din = 8'h00; div = 8'h00; autoRd = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sclk", int'(sclk), 0);
        check("rst_mosi", int'(mosi), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovr", int'(ovr), 0);
        check("rst_dout", int'(dout), 8'h00);
        res = 1'b0;

        // Loopback at full speed
        misoMode = 0;
        startTx(8'hA5, 0, 8'hA5, 1'b1, 1'b1, k);
        waitIdle(100);

        // 400 kHz with slave returning 3C
        slaveReg = 8'h3C;
        misoMode = 1;
        startTx(8'h81, 59, 8'h3C, 1'b1, 1'b1, k);
        waitIdle(2000);

        // Auto-read starts a 0xFF transfer; without AUTO nothing happens
        misoMode = 2;
        autoRd   = 1'b1;
        startTx(8'h00, 0, 8'hFF, 1'b0, 1'b1, k);
        waitIdle(100);
        autoRd = 1'b0;
        @(negedge clk); rdStb = 1'b1;
        @(negedge clk); rdStb = 1'b0;
        check("noauto_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("noauto_busy_later", int'(busy), 0);
        check("noauto_dout", int'(dout), 8'hFF);

        // Overrun while busy, cleared by read
        misoMode = 0;
        startTx(8'h5A, 0, 8'h5A, 1'b1, 1'b1, k);
        repeat (3) @(negedge clk);
        wrStb = 1'b1; din = 8'h00;
        @(negedge clk); wrStb = 1'b0;
        check("ovr_set", int'(ovr), 1);
        check("ovr_busy", int'(busy), 1);
        waitIdle(100);
        @(negedge clk); rdStb = 1'b1;
        @(negedge clk); rdStb = 1'b0;
        check("ovr_clear", int'(ovr), 0);

        // Start on the completing edge is rejected; on the next edge accepted
        startTx(8'hC3, 0, 8'hC3, 1'b1, 1'b1, k);
        kDone = k + 16;
        while (cyc < kDone - 1) @(negedge clk);
        wrStb = 1'b1; din = 8'h96;
        @(negedge clk);
        check("b2b_ovr", int'(ovr), 1);
        check("b2b_busy", int'(busy), 0);
        e.txExp = 8'h96; e.rxExp = 8'h96;
        e.doneCyc = kDone + 1 + 16; e.firstRise = kDone + 2; e.period = 2;
        sbQ.push_back(e);
        @(negedge clk); wrStb = 1'b0;
        check("b2b_accept_busy", int'(busy), 1);
        waitIdle(100);

        // DIV change mid-transfer is ignored until the next start
        startTx(8'hE7, 0, 8'hE7, 1'b1, 1'b1, k);
        @(negedge clk); div = 8'd5;
        waitIdle(100);
        startTx(8'h18, 5, 8'h18, 1'b1, 1'b1, k);
        waitIdle(300);

        // Reset mid-transfer aborts without DONE
        startTx(8'h77, 3, 8'h00, 1'b1, 1'b0, k);
        repeat (20) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        check("abort_sclk", int'(sclk), 0);
        check("abort_mosi", int'(mosi), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_dout", int'(dout), 8'h00);
        repeat (80) @(negedge clk);
        check("abort_busy_later", int'(busy), 0);

        check("sb_empty", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
